// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target.
// Contents:
//   state_t             - protocol FSM states
//   ACK / NACK          - SDA levels of the acknowledge bit
//   DEFAULT_TARGET_ADDR - default 7-bit bus address
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam logic [6:0] DEFAULT_TARGET_ADDR = 7'h50;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes the raw SCL/SDA lines into the clk domain and detects bus events.
// Ports:
//   clk, reset            - system clock, asynchronous active-low reset
//   scl, sda              - raw bus lines
//   scl_s, sda_s          - synchronized levels (2-FF)
//   scl_rise, scl_fall    - one-clk pulses on synchronized SCL edges
//   start_det, stop_det   - one-clk pulses: SDA falls / rises while SCL high
module i2c_bus_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda,
  output logic scl_s,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // [1] is the synchronized level, [2] the previous value for edge detection.
  logic [2:0] scl_pipe_reg;
  logic [2:0] sda_pipe_reg;

  // Reset to the idle bus level (both lines high) so no edge fires on release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_pipe_reg <= '1;
      sda_pipe_reg <= '1;
    end else begin
      scl_pipe_reg <= {scl_pipe_reg[1:0], scl};
      sda_pipe_reg <= {sda_pipe_reg[1:0], sda};
    end
  end

  assign scl_s    = scl_pipe_reg[1];
  assign sda_s    = sda_pipe_reg[1];
  assign scl_rise = scl_pipe_reg[1] & ~scl_pipe_reg[2];
  assign scl_fall = ~scl_pipe_reg[1] & scl_pipe_reg[2];

  // SCL must be high on both samples so an SCL edge never looks like START/STOP.
  assign start_det = scl_pipe_reg[1] & scl_pipe_reg[2] & sda_pipe_reg[2] & ~sda_pipe_reg[1];
  assign stop_det  = scl_pipe_reg[1] & scl_pipe_reg[2] & ~sda_pipe_reg[2] & sda_pipe_reg[1];

endmodule

// File: rtl/i2c_target.sv
// I2C target with NUM_REGS 8-bit registers behind an auto-incrementing pointer.
// Ports:
//   clk, reset   - system clock (>= 8x SCL), asynchronous active-low reset
//   i2c_scl      - bus clock (never stretched)
//   i2c_sda      - open-drain data, driven 0 or released
//   host_addr    - local read index
//   host_rdata   - regs[host_addr], one cycle latency
//   wr_strobe    - one-cycle pulse when a bus write updates a register
//   wr_index     - index written, valid with wr_strobe
//   busy         - addressed transaction in progress
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = DEFAULT_TARGET_ADDR,
  parameter int         NUM_REGS    = 8,
  parameter int         PTR_W       = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i2c_scl,
  inout  wire              i2c_sda,
  input  logic [PTR_W-1:0] host_addr,
  output logic [7:0]       host_rdata,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_index,
  output logic             busy
);

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl       (i2c_scl),
    .sda       (i2c_sda),
    .scl_s     (scl_s),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_t           state_reg, state_next;
  logic [2:0]       bit_cnt_reg, bit_cnt_next;
  logic [6:0]       shift_reg, shift_next;      // bit 7 is never needed after it is driven/received
  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic             sda_low_reg, sda_low_next;
  logic             busy_reg, busy_next;
  logic             rw_reg, rw_next;
  logic             first_reg, first_next;
  logic             ack_seen_reg, ack_seen_next;
  logic             wr_strobe_reg;
  logic [PTR_W-1:0] wr_index_reg;
  logic [7:0]       host_rdata_reg;
  logic [7:0]       regs [NUM_REGS];
  logic             we;
  logic [7:0]       rx_byte;

  // Open drain: only ever pull low.
  assign i2c_sda = sda_low_reg ? ACK : 1'bz;

  assign rx_byte = {shift_reg, sda_s};

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    ptr_next      = ptr_reg;
    sda_low_next  = sda_low_reg;
    busy_next     = busy_reg;
    rw_next       = rw_reg;
    first_next    = first_reg;
    ack_seen_next = ack_seen_reg;
    we            = 1'b0;

    if (stop_det) begin
      state_next   = IDLE;
      sda_low_next = 1'b0;
      busy_next    = 1'b0;
    end else if (start_det) begin
      // Repeated START discards any partial byte; nothing is written.
      state_next   = ADDR;
      bit_cnt_next = '0;
      sda_low_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: ;
        ADDR: if (scl_rise) begin
          shift_next   = rx_byte[6:0];
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            if (rx_byte[7:1] == TARGET_ADDR) begin
              state_next = ADDR_ACK;
              rw_next    = rx_byte[0];
              busy_next  = 1'b1;
            end else begin
              state_next = WAIT_STOP;
              busy_next  = 1'b0;
            end
          end
        end
        // sda_low_reg distinguishes the fall that starts the ACK from the one that ends it.
        ADDR_ACK: if (scl_fall) begin
          if (!sda_low_reg) begin
            sda_low_next = 1'b1;
          end else if (rw_reg) begin
            state_next   = RD_DATA;
            shift_next   = regs[ptr_reg][6:0];
            sda_low_next = ~regs[ptr_reg][7];
            bit_cnt_next = '0;
          end else begin
            state_next   = WR_DATA;
            sda_low_next = 1'b0;
            first_next   = 1'b1;
            bit_cnt_next = '0;
          end
        end
        WR_DATA: if (scl_rise) begin
          shift_next   = rx_byte[6:0];
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            state_next = WR_ACK;
            if (first_reg) begin
              ptr_next   = rx_byte[PTR_W-1:0];
              first_next = 1'b0;
            end else begin
              we       = 1'b1;
              ptr_next = ptr_reg + PTR_W'(1);
            end
          end
        end
        WR_ACK: if (scl_fall) begin
          if (!sda_low_reg) begin
            sda_low_next = 1'b1;
          end else begin
            sda_low_next = 1'b0;
            state_next   = WR_DATA;
            bit_cnt_next = '0;
          end
        end
        // bit_cnt counts falls here: the MSB went out on the fall that entered the state.
        RD_DATA: if (scl_fall) begin
          if (bit_cnt_reg == 3'd7) begin
            sda_low_next  = 1'b0;
            ptr_next      = ptr_reg + PTR_W'(1);
            ack_seen_next = 1'b0;
            state_next    = RD_ACK;
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            sda_low_next = ~shift_reg[6];
            shift_next   = {shift_reg[5:0], 1'b0};
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_s == NACK) state_next = WAIT_STOP;
            else               ack_seen_next = 1'b1;
          end else if (scl_fall && ack_seen_reg) begin
            state_next   = RD_DATA;
            shift_next   = regs[ptr_reg][6:0];
            sda_low_next = ~regs[ptr_reg][7];
            bit_cnt_next = '0;
          end
        end
        WAIT_STOP: sda_low_next = 1'b0;
        default:   state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      ptr_reg       <= '0;
      sda_low_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      rw_reg        <= 1'b0;
      first_reg     <= 1'b0;
      ack_seen_reg  <= 1'b0;
      wr_strobe_reg <= 1'b0;
      wr_index_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      ptr_reg       <= ptr_next;
      sda_low_reg   <= sda_low_next;
      busy_reg      <= busy_next;
      rw_reg        <= rw_next;
      first_reg     <= first_next;
      ack_seen_reg  <= ack_seen_next;
      wr_strobe_reg <= we;
      if (we) wr_index_reg <= ptr_reg;
    end
  end

  // Register file; host read sees the pre-write value in the write cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      host_rdata_reg <= '0;
    end else begin
      if (we) regs[ptr_reg] <= rx_byte;
      host_rdata_reg <= regs[host_addr];
    end
  end

  assign host_rdata = host_rdata_reg;
  assign wr_strobe  = wr_strobe_reg;
  assign wr_index   = wr_index_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_i2c_target.sv
module tb_i2c_target;
  import i2c_pkg::*;

  localparam int NR = 8;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          scl = 1'b1;
  logic          sda_low_m = 1'b0;
  wire           sda_bus;
  logic [PW-1:0] host_addr = '0;
  logic [7:0]    host_rdata;
  logic          wr_strobe;
  logic [PW-1:0] wr_index;
  logic          busy;

  assign sda_bus = sda_low_m ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_target #(.TARGET_ADDR(7'h50), .NUM_REGS(NR)) dut (
    .clk        (clk),
    .reset      (reset),
    .i2c_scl    (scl),
    .i2c_sda    (sda_bus),
    .host_addr  (host_addr),
    .host_rdata (host_rdata),
    .wr_strobe  (wr_strobe),
    .wr_index   (wr_index),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: register contents and pointer, updated per transaction.
  logic [7:0]    model_regs [NR];
  int            model_ptr;
  logic [7:0]    wbuf [4];
  logic [PW-1:0] strobe_log [$];
  int            drove_cnt = 0;
  int            last_s0;

  always @(negedge clk) if (wr_strobe === 1'b1) strobe_log.push_back(wr_index);
  always @(negedge clk) if (!sda_low_m && sda_bus === 1'b0) drove_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    tick(4); sda_low_m = ~b; tick(4); scl = 1'b1; tick(8); scl = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    tick(4); sda_low_m = 1'b0; tick(4); scl = 1'b1; tick(4); b = sda_bus; tick(4); scl = 1'b0;
  endtask

  task automatic start_cond();
    if (scl == 1'b0) begin
      tick(4); sda_low_m = 1'b0; tick(4); scl = 1'b1; tick(8);
    end
    sda_low_m = 1'b1; tick(8); scl = 1'b0;
  endtask

  task automatic stop_cond();
    tick(4); sda_low_m = 1'b1; tick(4); scl = 1'b1; tick(8); sda_low_m = 1'b0; tick(8);
  endtask

  // ack = 1 when the target acknowledged
  task automatic send_byte(input logic [7:0] v, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    recv_bit(b);
    ack = (b == ACK);
  endtask

  task automatic recv_byte(output logic [7:0] v, input logic master_ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      v[i] = b;
    end
    send_bit(master_ack ? ACK : NACK);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++) begin
      host_addr = PW'(i);
      tick(1);
      check($sformatf("%s reg[%0d]", tag, i), host_rdata, model_regs[i]);
    end
  endtask

  task automatic bus_write(input logic [6:0] a, input int n, input string tag);
    logic ack;
    bit match;
    int s0, d0;
    logic [PW-1:0] exp_idx [$];
    match = (a == 7'h50);
    s0 = strobe_log.size(); d0 = drove_cnt; last_s0 = s0;
    start_cond();
    send_byte({a, 1'b0}, ack);
    check({tag, " addr ack"}, ack, match);
    check({tag, " busy after addr"}, busy, match);
    for (int i = 0; i < n; i++) begin
      send_byte(wbuf[i], ack);
      check($sformatf("%s data%0d ack", tag, i), ack, match);
      if (match) begin
        if (i == 0) model_ptr = int'(wbuf[0]) % NR;
        else begin
          model_regs[model_ptr] = wbuf[i];
          exp_idx.push_back(PW'(model_ptr));
          model_ptr = (model_ptr + 1) % NR;
        end
      end
    end
    stop_cond();
    check({tag, " busy after stop"}, busy, 0);
    check({tag, " strobe count"}, strobe_log.size() - s0, exp_idx.size());
    for (int i = 0; i < exp_idx.size() && s0 + i < strobe_log.size(); i++)
      check($sformatf("%s wr_index%0d", tag, i), strobe_log[s0 + i], exp_idx[i]);
    if (!match) check({tag, " sda never driven"}, drove_cnt - d0, 0);
    $display("txn %s: write addr=0x%02h bytes=%0d", tag, a, n);
  endtask

  task automatic bus_read(input logic [6:0] a, input int n, input bit set_ptr,
                          input logic [7:0] pb, input string tag);
    logic ack;
    logic [7:0] v;
    bit match;
    int s0, d0;
    match = (a == 7'h50);
    s0 = strobe_log.size(); d0 = drove_cnt;
    start_cond();
    if (set_ptr) begin
      send_byte({a, 1'b0}, ack);
      check({tag, " ptr addr ack"}, ack, match);
      send_byte(pb, ack);
      check({tag, " ptr ack"}, ack, match);
      if (match) model_ptr = int'(pb) % NR;
      start_cond();
    end
    send_byte({a, 1'b1}, ack);
    check({tag, " rd addr ack"}, ack, match);
    if (match) begin
      for (int i = 0; i < n; i++) begin
        recv_byte(v, i != n - 1);
        check($sformatf("%s rdata%0d", tag, i), v, model_regs[model_ptr]);
        model_ptr = (model_ptr + 1) % NR;
      end
      tick(6);
      check({tag, " sda released after nack"}, sda_bus, 1);
    end
    stop_cond();
    check({tag, " busy after stop"}, busy, 0);
    check({tag, " no strobe"}, strobe_log.size() - s0, 0);
    if (!match) check({tag, " sda never driven"}, drove_cnt - d0, 0);
    $display("txn %s: read addr=0x%02h bytes=%0d set_ptr=%0d", tag, a, n, set_ptr);
  endtask

  typedef struct {
    logic [6:0] addr;
    int         n;
    logic [7:0] ptr_b;
    logic [7:0] d0;
    logic [7:0] d1;
    int         exp_n;
    logic [2:0] exp_i0;
    logic [2:0] exp_i1;
  } wvec_t;

  wvec_t vt [4];

  initial begin
    logic       ack;
    logic [6:0] ra;
    int         rn;
    for (int i = 0; i < NR; i++) model_regs[i] = 8'h00;
    model_ptr = 0;

    // Reset state
    #1;
    check("reset busy", busy, 0);
    check("reset wr_strobe", wr_strobe, 0);
    check("reset host_rdata", host_rdata, 0);
    check("reset sda", sda_bus, 1);
    tick(3);
    reset = 1'b1;
    tick(3);

    // Table-driven write transactions
    vt[0] = '{7'h50, 3, 8'h02, 8'hA5, 8'h3C, 2, 3'd2, 3'd3};
    vt[1] = '{7'h51, 2, 8'h00, 8'hFF, 8'h00, 0, 3'd0, 3'd0};
    vt[2] = '{7'h50, 3, 8'h07, 8'h11, 8'h22, 2, 3'd7, 3'd0};
    vt[3] = '{7'h50, 3, 8'h0A, 8'h66, 8'h77, 2, 3'd2, 3'd3};
    for (int k = 0; k < 4; k++) begin
      wbuf[0] = vt[k].ptr_b; wbuf[1] = vt[k].d0; wbuf[2] = vt[k].d1;
      bus_write(vt[k].addr, vt[k].n, $sformatf("vec%0d", k));
      check($sformatf("vec%0d strobes", k), strobe_log.size() - last_s0, vt[k].exp_n);
      if (vt[k].exp_n == 2 && strobe_log.size() - last_s0 == 2) begin
        check($sformatf("vec%0d idx0", k), strobe_log[last_s0], vt[k].exp_i0);
        check($sformatf("vec%0d idx1", k), strobe_log[last_s0 + 1], vt[k].exp_i1);
      end
      check_regs($sformatf("vec%0d", k));
    end

    // Read with repeated START; pointer ends at 5
    wbuf[0] = 8'h03; wbuf[1] = 8'h3C; wbuf[2] = 8'h00; wbuf[3] = 8'h5A;
    bus_write(7'h50, 4, "preload");
    bus_read(7'h50, 2, 1'b1, 8'h03, "read");
    check("read ptr model", model_ptr, 5);
    bus_read(7'h50, 1, 1'b0, 8'h00, "read_ptr5");

    // Abort: STOP after 4 data bits
    start_cond();
    send_byte(8'hA0, ack);
    check("abort addr ack", ack, 1);
    send_byte(8'h01, ack);
    check("abort ptr ack", ack, 1);
    model_ptr = 1;
    last_s0 = strobe_log.size();
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    stop_cond();
    $display("txn abort: stop after 4 data bits");
    check("abort busy", busy, 0);
    check("abort no strobe", strobe_log.size() - last_s0, 0);
    check_regs("abort");
    bus_read(7'h50, 1, 1'b0, 8'h00, "after_abort");

    // Reset while the target drives an ACK
    start_cond();
    for (int i = 7; i >= 0; i--) send_bit(i == 5 || i == 7);
    tick(1); sda_low_m = 1'b0; tick(4);
    check("rst ack driven", sda_bus, 0);
    reset = 1'b0;
    #1;
    check("rst sda released", sda_bus, 1);
    check("rst busy", busy, 0);
    $display("txn reset: asserted during address ACK");
    for (int i = 0; i < NR; i++) model_regs[i] = 8'h00;
    model_ptr = 0;
    tick(3);
    reset = 1'b1;
    tick(2);
    check_regs("rst");
    stop_cond();
    wbuf[0] = 8'h01; wbuf[1] = 8'hC3;
    bus_write(7'h50, 2, "post_reset");
    check_regs("post_reset");

    // Randomized transactions against the model
    for (int t = 0; t < 24; t++) begin
      ra = ($urandom_range(0, 3) == 0) ? (7'h50 ^ 7'($urandom_range(1, 127))) : 7'h50;
      if ($urandom_range(0, 1) == 0) begin
        rn = $urandom_range(1, 4);
        for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
        bus_write(ra, rn, $sformatf("rnd%0d", t));
      end else begin
        bus_read(ra, $urandom_range(1, 3), 1'($urandom_range(0, 1)), 8'($urandom),
                 $sformatf("rnd%0d", t));
      end
    end
    check_regs("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
